block_b_sched: RTL

- Shares one block_b datapath between NUM_REQ requesters.
- Round-robin arbitrates requests and drives the granted operand onto block_b data_in, holding it until block_b raises data_en.
- Returns the 1-bit result tagged with the requester ID.
- A timeout watchdog resets block_b if it never completes; the scheduler sits directly upstream of block_b.

---
 rtl/block_b_sched_pkg.sv | 17 +
 rtl/block_b_sched_rr_arb.sv | 55 +++++
 rtl/block_b_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/block_b_sched_pkg.sv
// Shared types and constants for the block_b request scheduler.
package block_b_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RECOVER
  } state_e;

  localparam int unsigned RECOVER_CYCLES = 2;

  // Requester ID width; a single requester still needs one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_b_sched_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward and advances it past each granted index.
module rr_arb
  import block_b_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W:0]   cand;

  // One extra bit on cand so ptr+i never overflows before the wrap subtraction.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (!grant_valid && req[cand[ID_W-1:0]]) begin
        grant[cand[ID_W-1:0]] = 1'b1;
        grant_idx             = cand[ID_W-1:0];
        grant_valid           = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/block_b_sched.sv
// Shares one block_b datapath among NUM_REQ requesters with round-robin grant,
// tagged responses and a timeout watchdog that resets block_b.
module block_b_sched
  import block_b_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned TIMEOUT    = 15,
  localparam int unsigned ID_W = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         blk_data_in,
  output logic                          blk_rst,
  input  logic                          blk_data_out,
  input  logic                          blk_data_en,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_data,
  output logic                          rsp_timeout,
  output logic                          busy
);

  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned RCNT_W = $clog2(RECOVER_CYCLES + 1);

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_WIDTH-1:0] blk_data_in_q, blk_data_in_d;
  logic                  blk_rst_q, blk_rst_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_data_q, rsp_data_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic                  advance;

  assign advance = (state_q == IDLE);

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .advance     (advance),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Accept is combinational so the grant and the transfer share one cycle.
  assign req_ready   = (state_q == IDLE && !rst) ? grant : '0;
  assign busy        = (state_q != IDLE);
  assign blk_data_in = blk_data_in_q;
  assign blk_rst     = blk_rst_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rcnt_d        = rcnt_q;
    id_d          = id_q;
    blk_data_in_d = blk_data_in_q;
    blk_rst_d     = blk_rst_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          blk_data_in_d = req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
          id_d          = grant_idx;
          timer_d       = '0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (blk_data_en) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = blk_data_out;
          rsp_id_d      = id_q;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = 1'b0;
          rsp_id_d      = id_q;
          rsp_timeout_d = 1'b1;
          blk_rst_d     = 1'b1;
          rcnt_d        = '0;
          state_d       = RECOVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RECOVER: begin
        if (rcnt_q == RCNT_W'(RECOVER_CYCLES - 1)) begin
          blk_rst_d = 1'b0;
          state_d   = IDLE;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      rcnt_q        <= '0;
      id_q          <= '0;
      blk_data_in_q <= '0;
      blk_rst_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rcnt_q        <= rcnt_d;
      id_q          <= id_d;
      blk_data_in_q <= blk_data_in_d;
      blk_rst_q     <= blk_rst_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule
